m_cache_refill: RTL and testbench
=================================

M_CACHE_REFILL -- requirements
Module: m_cache_refill

Interface
REQ-001 SHALL have no parameters; address width is `DADDR_WIDTH from define.v; line = 4 x 32-bit words (16 bytes).
REQ-002 i_clk  in  1  single clock; all state changes on posedge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_req  in  1  load-miss request from core (cache o_hit=0 on a load).
REQ-005 i_addr  in  `DADDR_WIDTH  miss byte address.
REQ-006 o_busy  out  1  refill in progress; core stalls and issues no cache writes.
REQ-007 o_done  out  1  one-cycle pulse: line installed, o_word valid.
REQ-008 o_word  out  32  missed word (line word i_addr[3:2]).
REQ-009 o_mreq  out  1  memory burst-read request.
REQ-010 o_maddr  out  `DADDR_WIDTH  line-aligned burst address (bits [3:0]=0).
REQ-011 i_mack  in  1  memory accepts request.
REQ-012 i_mvalid  in  1  memory data beat valid.
REQ-013 i_mdata  in  32  memory data beat.
REQ-014 o_ie  out  1  cache install enable.
REQ-015 o_iaddr  out  `DADDR_WIDTH  cache install address (line-aligned).
REQ-016 o_idata  out  128  cache install data; word k in bits [k*32+:32].

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, INSTALL; o_busy = (state != IDLE).
REQ-018 IDLE: i_req=1 -> latch {i_addr[DADDR_WIDTH-1:4],4'b0} as line address and i_addr[3:2] as critical index; next REQ; i_req=0 -> stay.
REQ-019 REQ: o_mreq=1, o_maddr=latched line address; i_mack=1 -> WAIT with beat counter=0; else hold REQ, o_mreq and o_maddr stable.
REQ-020 WAIT: each i_mvalid=1 stores i_mdata into line word[counter], counter increments (2-bit); 4th beat (counter=3) -> INSTALL.
REQ-021 Beats SHALL arrive in ascending word order 0..3; gaps (i_mvalid=0) between beats are allowed and only stall.
REQ-022 INSTALL: exactly one cycle; o_ie=1, o_iaddr=line address, o_idata=assembled line, o_done=1, o_word=line word[critical index]; next IDLE.
REQ-023 o_ie, o_done, o_mreq SHALL be 0 in every state not listed above; o_ie never high for more than one cycle per refill.
REQ-024 i_req while o_busy=1 SHALL be ignored (no queueing); i_req in the IDLE cycle right after INSTALL starts a new refill.
REQ-025 i_mvalid outside WAIT (including the i_mack cycle in REQ) SHALL be ignored; i_mack outside REQ ignored.
REQ-026 i_addr changes after acceptance SHALL NOT affect the refill in progress.
REQ-027 Minimum latency: i_req at cycle 0, i_mack at cycle 1, beats cycles 2-5 -> o_ie/o_done at cycle 6, IDLE at cycle 7.
REQ-028 Line address wrap: line 0xFFFF_FFF0 (32-bit) SHALL refill normally; no address arithmetic beyond alignment.

Reset
REQ-029 i_rst=1 at any posedge -> state IDLE, counter=0, o_busy=0, o_done=0, o_mreq=0, o_ie=0, o_maddr=0, o_iaddr=0, o_idata=0, o_word=0.
REQ-030 Reset mid-refill SHALL abandon the refill with no install; beats arriving after reset are ignored until a new REQ-state handshake.
REQ-031 i_req coincident with i_rst SHALL be dropped.

Verification
REQ-032 i_req, i_addr=0x0000_1238, i_mack at first REQ cycle, beats 0xA0,0xA1,0xA2,0xA3 back-to-back -> o_maddr=0x1230; cycle 6 o_ie=1, o_iaddr=0x1230, o_idata={0xA3,0xA2,0xA1,0xA0}, o_word=0xA2, o_done=1.
REQ-033 i_mack delayed 3 cycles, beats with 2-cycle gaps -> o_mreq held 4 cycles, o_maddr stable, install data correct, single o_ie pulse.
REQ-034 i_mvalid=1 with data 0xBAD during REQ and IDLE -> ignored; o_idata excludes 0xBAD.
REQ-035 Second i_req pulses during WAIT -> ignored; exactly one o_done; i_req on the IDLE cycle after INSTALL starts refill of new address.
REQ-036 i_rst after 2 beats -> next cycle all outputs 0, IDLE; remaining 2 beats ignored; no o_ie.
REQ-037 i_req with i_addr=0xFFFF_FFFC -> o_maddr=0xFFFF_FFF0, o_word = beat 3.

Source files
------------

// File: rtl/m_cache_refill.sv
// m_cache_refill: load-miss line refill controller.
// Latches the missed line on a core request, issues one burst read to memory,
// collects four 32-bit beats in ascending word order, then installs the line
// into the cache for exactly one cycle while returning the critical word.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no refill active; waiting for a core load-miss request
//   REQ     | burst read requested; holding o_mreq/o_maddr until i_mack
//   WAIT    | collecting data beats 0..3; gaps between beats just stall
//   INSTALL | single cycle: line write to cache, o_done and critical word

`ifndef DADDR_WIDTH
`define DADDR_WIDTH 32
`endif

module m_cache_refill (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic [`DADDR_WIDTH-1:0] i_addr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [31:0]             o_word,
  output logic                    o_mreq,
  output logic [`DADDR_WIDTH-1:0] o_maddr,
  input  logic                    i_mack,
  input  logic                    i_mvalid,
  input  logic [31:0]             i_mdata,
  output logic                    o_ie,
  output logic [`DADDR_WIDTH-1:0] o_iaddr,
  output logic [127:0]            o_idata
);

  localparam int AW = `DADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_INSTALL = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [AW-5:0]  r_line_tag;
  logic [1:0]     r_crit;
  logic [1:0]     r_cnt;
  logic [127:0]   r_line;

  logic           w_accept;
  logic           w_start_burst;
  logic           w_beat;
  logic [AW-1:0]  w_line_addr;
  logic [31:0]    w_crit_word;

  // Byte-offset bits below the word index never influence a line refill.
  logic           w_unused;
  assign w_unused = &{1'b0, i_addr[1:0]};

  assign w_line_addr = {r_line_tag, 4'b0000};
  assign w_crit_word = r_line[{r_crit, 5'b00000} +: 32];
  assign o_busy      = (r_state != ST_IDLE);

  // State register; reset abandons any refill in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and Moore outputs; interface outputs read zero outside
  // the state in which they carry meaning.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_start_burst = 1'b0;
    w_beat        = 1'b0;
    o_mreq        = 1'b0;
    o_maddr       = '0;
    o_ie          = 1'b0;
    o_iaddr       = '0;
    o_idata       = '0;
    o_done        = 1'b0;
    o_word        = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        o_mreq  = 1'b1;
        o_maddr = w_line_addr;
        if (i_mack) begin
          w_start_burst = 1'b1;
          w_state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_mvalid) begin
          w_beat = 1'b1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = ST_INSTALL;
          end
        end
      end
      ST_INSTALL: begin
        o_ie        = 1'b1;
        o_iaddr     = w_line_addr;
        o_idata     = r_line;
        o_done      = 1'b1;
        o_word      = w_crit_word;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture and beat assembly; the line address and critical index
  // are frozen at acceptance so later i_addr changes cannot disturb the refill.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_tag <= '0;
      r_crit     <= '0;
      r_cnt      <= '0;
      r_line     <= '0;
    end else begin
      if (w_accept) begin
        r_line_tag <= i_addr[AW-1:4];
        r_crit     <= i_addr[3:2];
      end
      if (w_start_burst) begin
        r_cnt <= 2'd0;
      end
      if (w_beat) begin
        r_line[{r_cnt, 5'b00000} +: 32] <= i_mdata;
        r_cnt                           <= r_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_m_cache_refill.sv
// Testbench for m_cache_refill: scenario tasks drive refills with randomized
// handshake delays, beat gaps and ignored-input noise, and check against
// expectations derived from the line-refill rules.

`ifndef DADDR_WIDTH
`define DADDR_WIDTH 32
`endif

module tb_m_cache_refill;

  localparam int AW = `DADDR_WIDTH;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_req;
  logic [AW-1:0]  i_addr;
  logic           o_busy;
  logic           o_done;
  logic [31:0]    o_word;
  logic           o_mreq;
  logic [AW-1:0]  o_maddr;
  logic           i_mack;
  logic           i_mvalid;
  logic [31:0]    i_mdata;
  logic           o_ie;
  logic [AW-1:0]  o_iaddr;
  logic [127:0]   o_idata;

  int n_cmp = 0;
  int n_err = 0;

  m_cache_refill dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_word   (o_word),
    .o_mreq   (o_mreq),
    .o_maddr  (o_maddr),
    .i_mack   (i_mack),
    .i_mvalid (i_mvalid),
    .i_mdata  (i_mdata),
    .o_ie     (o_ie),
    .o_iaddr  (o_iaddr),
    .o_idata  (o_idata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary, required completion");
    $fatal(1);
  end

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  // One complete refill. Expectations come from the refill rules: line address
  // is the request address with the low nibble cleared, the installed line is
  // the four beats in order, and the returned word is the beat selected by
  // address bits [3:2]. Install happens in the cycle right after the 4th beat.
  task automatic run_refill(input logic [AW-1:0] addr, input int mack_delay,
                            input int gap_max, input bit junk, input bit noise,
                            input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3);
    logic [31:0]   beats [4];
    logic [AW-1:0] exp_line;
    logic [127:0]  exp_data;
    logic [31:0]   exp_word;
    int            g;
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    exp_line = {addr[AW-1:4], 4'h0};
    exp_data = {b3, b2, b1, b0};
    exp_word = beats[addr[3:2]];

    n_cmp++;
    if (o_busy !== 1'b0 || o_mreq !== 1'b0 || o_ie !== 1'b0) begin
      n_err++;
      $display("FAIL idle_entry: busy=%b mreq=%b ie=%b, required 0 0 0", o_busy, o_mreq, o_ie);
    end
    i_req    = 1'b1;
    i_addr   = addr;
    i_mvalid = junk;
    i_mack   = junk;
    i_mdata  = 32'h0000_0BAD;
    step();
    i_req  = 1'b0;
    i_addr = $urandom;
    i_mack = 1'b0;

    for (int d = 0; d <= mack_delay; d++) begin
      n_cmp++;
      if (o_mreq !== 1'b1 || o_maddr !== exp_line || o_busy !== 1'b1 ||
          o_ie !== 1'b0 || o_done !== 1'b0) begin
        n_err++;
        $display("FAIL req_phase[%0d]: mreq=%b maddr=%h busy=%b ie=%b done=%b, required 1 %h 1 0 0",
                 d, o_mreq, o_maddr, o_busy, o_ie, o_done, exp_line);
      end
      i_mack   = (d == mack_delay);
      i_mvalid = junk;
      i_mdata  = 32'h0000_0BAD;
      i_req    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    i_mack = 1'b0;
    i_req  = 1'b0;

    for (int b = 0; b < 4; b++) begin
      g = $urandom_range(0, gap_max);
      for (int k = 0; k < g; k++) begin
        i_mvalid = 1'b0;
        i_mdata  = $urandom;
        i_req    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        i_mack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        n_cmp++;
        if (o_busy !== 1'b1 || o_mreq !== 1'b0 || o_ie !== 1'b0 || o_done !== 1'b0) begin
          n_err++;
          $display("FAIL wait_gap[%0d]: busy=%b mreq=%b ie=%b done=%b, required 1 0 0 0",
                   b, o_busy, o_mreq, o_ie, o_done);
        end
        step();
      end
      i_mvalid = 1'b1;
      i_mdata  = beats[b];
      i_req    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      i_mack   = 1'b0;
      n_cmp++;
      if (o_busy !== 1'b1 || o_mreq !== 1'b0 || o_ie !== 1'b0 || o_done !== 1'b0) begin
        n_err++;
        $display("FAIL wait_beat[%0d]: busy=%b mreq=%b ie=%b done=%b, required 1 0 0 0",
                 b, o_busy, o_mreq, o_ie, o_done);
      end
      step();
    end
    i_mvalid = 1'b0;
    i_req    = 1'b0;
    i_mack   = 1'b0;

    n_cmp++;
    if (o_ie !== 1'b1 || o_done !== 1'b1 || o_iaddr !== exp_line ||
        o_idata !== exp_data || o_word !== exp_word || o_busy !== 1'b1 || o_mreq !== 1'b0) begin
      n_err++;
      $display("FAIL install: ie=%b done=%b iaddr=%h idata=%h word=%h busy=%b mreq=%b, required 1 1 %h %h %h 1 0",
               o_ie, o_done, o_iaddr, o_idata, o_word, o_busy, o_mreq, exp_line, exp_data, exp_word);
    end
    i_mvalid = junk;
    i_mdata  = 32'h0000_0BAD;
    step();
    i_mvalid = 1'b0;

    n_cmp++;
    if (o_busy !== 1'b0 || o_ie !== 1'b0 || o_done !== 1'b0) begin
      n_err++;
      $display("FAIL post_install: busy=%b ie=%b done=%b, required 0 0 0", o_busy, o_ie, o_done);
    end
  endtask

  task automatic test_reset;
    i_rst    = 1'b1;
    i_req    = 1'b1;
    i_addr   = 32'h0000_5678;
    i_mack   = 1'b1;
    i_mvalid = 1'b1;
    i_mdata  = 32'h0000_0BAD;
    step();
    step();
    n_cmp++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_mreq !== 1'b0 || o_ie !== 1'b0 ||
        o_maddr !== '0 || o_iaddr !== '0 || o_idata !== '0 || o_word !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b mreq=%b ie=%b maddr=%h iaddr=%h idata=%h word=%h, required all 0",
               o_busy, o_done, o_mreq, o_ie, o_maddr, o_iaddr, o_idata, o_word);
    end
    i_rst    = 1'b0;
    i_req    = 1'b0;
    i_mack   = 1'b0;
    i_mvalid = 1'b0;
    step();
    n_cmp++;
    if (o_busy !== 1'b0 || o_mreq !== 1'b0) begin
      n_err++;
      $display("FAIL req_during_reset: busy=%b mreq=%b, required 0 0", o_busy, o_mreq);
    end
  endtask

  task automatic test_basic;
    run_refill(32'h0000_1238, 0, 0, 1'b0, 1'b0,
               32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3);
  endtask

  task automatic test_delays;
    run_refill(32'h0000_4A04, 3, 2, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic test_ignored_inputs;
    for (int k = 0; k < 3; k++) begin
      i_mvalid = 1'b1;
      i_mack   = 1'b1;
      i_mdata  = 32'h0000_0BAD;
      step();
      n_cmp++;
      if (o_busy !== 1'b0 || o_mreq !== 1'b0 || o_ie !== 1'b0) begin
        n_err++;
        $display("FAIL idle_noise[%0d]: busy=%b mreq=%b ie=%b, required 0 0 0", k, o_busy, o_mreq, o_ie);
      end
    end
    i_mvalid = 1'b0;
    i_mack   = 1'b0;
    run_refill(32'h0000_2000, 2, 1, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic test_back_to_back;
    run_refill(32'h0000_3004, 0, 2, 1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
    run_refill(32'h0000_7F0C, 1, 0, 1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic test_mid_reset;
    i_req  = 1'b1;
    i_addr = 32'h0000_9990;
    step();
    i_req  = 1'b0;
    i_mack = 1'b1;
    step();
    i_mack = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_mvalid = 1'b1;
      i_mdata  = $urandom;
      step();
    end
    i_rst    = 1'b1;
    i_mvalid = 1'b1;
    i_mdata  = $urandom;
    step();
    n_cmp++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_mreq !== 1'b0 || o_ie !== 1'b0 ||
        o_maddr !== '0 || o_iaddr !== '0 || o_idata !== '0 || o_word !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b mreq=%b ie=%b maddr=%h iaddr=%h idata=%h word=%h, required all 0",
               o_busy, o_done, o_mreq, o_ie, o_maddr, o_iaddr, o_idata, o_word);
    end
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_mvalid = 1'b1;
      i_mdata  = $urandom;
      step();
      n_cmp++;
      if (o_busy !== 1'b0 || o_ie !== 1'b0 || o_done !== 1'b0) begin
        n_err++;
        $display("FAIL after_reset_beats[%0d]: busy=%b ie=%b done=%b, required 0 0 0", k, o_busy, o_ie, o_done);
      end
    end
    i_mvalid = 1'b0;
    run_refill(32'h0000_ABC8, 1, 1, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic test_wrap;
    run_refill(32'hFFFF_FFFC, 0, 1, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      run_refill($urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        step();
      end
    end
  endtask

  initial begin
    i_rst    = 1'b1;
    i_req    = 1'b0;
    i_addr   = '0;
    i_mack   = 1'b0;
    i_mvalid = 1'b0;
    i_mdata  = '0;
    test_reset();
    test_basic();
    test_delays();
    test_ignored_inputs();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
